// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch stage of the 5-stage ARM pipeline. Holds
//                the PC, drives the instruction-memory address, and captures
//                the fetched word plus PC+4 into the IF/ID pipeline register.
//                Also keeps saturating counts of stall and flush cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter int BIT_NUMBER = 32,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [BIT_NUMBER-1:0] branch_addr,
    output logic [BIT_NUMBER-1:0] imem_addr,
    input  logic [BIT_NUMBER-1:0] imem_rdata,
    output logic [BIT_NUMBER-1:0] ifid_pc,
    output logic [BIT_NUMBER-1:0] ifid_instr,
    output logic                  ifid_valid,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam logic [BIT_NUMBER-1:0] c_PC_STEP = BIT_NUMBER'(4);
    localparam logic [CNT_W-1:0]      c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]      c_CNT_MAX = '1;

    logic [BIT_NUMBER-1:0] r_pc;
    logic [BIT_NUMBER-1:0] r_ifid_pc;
    logic [BIT_NUMBER-1:0] r_ifid_instr;
    logic                  r_ifid_valid;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_flush_cnt;

    logic [BIT_NUMBER-1:0] w_pc_plus4;
    logic [BIT_NUMBER-1:0] w_branch_target;
    logic                  w_stall_evt;

    // Sequential PC increment wraps naturally at the top of the address space;
    // branch targets are forced word-aligned.
    assign w_pc_plus4      = r_pc + c_PC_STEP;
    assign w_branch_target = {branch_addr[BIT_NUMBER-1:2], 2'b00};
    // A branch in the same cycle as a freeze is a flush, not a stall.
    assign w_stall_evt     = freeze & ~branch_taken;

    // Next-PC select: branch redirect beats freeze beats sequential advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= '0;
        end else if (branch_taken) begin
            r_pc <= w_branch_target;
        end else if (!freeze) begin
            r_pc <= w_pc_plus4;
        end
    end

    // IF/ID register: flush on branch, hold on freeze, otherwise capture fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ifid_pc    <= '0;
            r_ifid_instr <= '0;
            r_ifid_valid <= 1'b0;
        end else if (branch_taken) begin
            r_ifid_pc    <= '0;
            r_ifid_instr <= '0;
            r_ifid_valid <= 1'b0;
        end else if (!freeze) begin
            r_ifid_pc    <= w_pc_plus4;
            r_ifid_instr <= imem_rdata;
            r_ifid_valid <= 1'b1;
        end
    end

    // Saturating stall counter; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall_evt && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
        end
    end

    // Saturating flush counter; every taken branch counts, even back-to-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_cnt <= '0;
        end else if (branch_taken && (r_flush_cnt != c_CNT_MAX)) begin
            r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
        end
    end

    assign imem_addr  = r_pc;
    assign ifid_pc    = r_ifid_pc;
    assign ifid_instr = r_ifid_instr;
    assign ifid_valid = r_ifid_valid;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage
//  Description : Scoreboard bench for if_stage. The driver applies directed
//                vectors and queues hand-computed post-edge state; a monitor
//                pops and compares on each falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam int c_BN   = 32;
    localparam int c_CW   = 4;

    logic            clk;
    logic            rst;
    logic            freeze;
    logic            branch_taken;
    logic [c_BN-1:0] branch_addr;
    logic [c_BN-1:0] imem_addr;
    logic [c_BN-1:0] imem_rdata;
    logic [c_BN-1:0] ifid_pc;
    logic [c_BN-1:0] ifid_instr;
    logic            ifid_valid;
    logic [c_CW-1:0] stall_cnt;
    logic [c_CW-1:0] flush_cnt;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] ins;
        logic        v;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t q[$];
    exp_t r_e;
    int   checks = 0;
    int   errors = 0;

    if_stage #(.BIT_NUMBER(c_BN), .CNT_W(c_CW)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .ifid_pc      (ifid_pc),
        .ifid_instr   (ifid_instr),
        .ifid_valid   (ifid_valid),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    // Instruction memory model: word tagged with its own address.
    assign imem_rdata = 32'hE000_0000 | imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare current DUT state against the oldest queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            r_e = q.pop_front();
            chk("imem_addr",  imem_addr,          r_e.pc);
            chk("ifid_pc",    ifid_pc,            r_e.ipc);
            chk("ifid_instr", ifid_instr,         r_e.ins);
            chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, r_e.v});
            chk("stall_cnt",  {28'd0, stall_cnt},  r_e.sc);
            chk("flush_cnt",  {28'd0, flush_cnt},  r_e.fc);
        end
    end

    // Apply one cycle of inputs and queue the expected state after the edge.
    task automatic step(input logic r, input logic f, input logic b, input logic [31:0] a,
                        input logic [31:0] epc, input logic [31:0] eipc, input logic [31:0] eins,
                        input logic ev, input logic [31:0] esc, input logic [31:0] efc);
        exp_t e;
        rst          = r;
        freeze       = f;
        branch_taken = b;
        branch_addr  = a;
        @(posedge clk);
        #1;
        e.pc = epc; e.ipc = eipc; e.ins = eins; e.v = ev; e.sc = esc; e.fc = efc;
        q.push_back(e);
    endtask

    localparam logic [31:0] c_I = 32'hE000_0000;

    initial begin
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;

        // Reset state
        step(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);

        // Sequential fetch, 4 cycles
        step(0, 0, 0, 0, 32'h04, 32'h04, c_I | 32'h0, 1, 0, 0);
        step(0, 0, 0, 0, 32'h08, 32'h08, c_I | 32'h4, 1, 0, 0);
        step(0, 0, 0, 0, 32'h0C, 32'h0C, c_I | 32'h8, 1, 0, 0);
        step(0, 0, 0, 0, 32'h10, 32'h10, c_I | 32'hC, 1, 0, 0);

        // Freeze 3 cycles at pc=0x08
        step(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step(0, 0, 0, 0, 32'h04, 32'h04, c_I | 32'h0, 1, 0, 0);
        step(0, 0, 0, 0, 32'h08, 32'h08, c_I | 32'h4, 1, 0, 0);
        step(0, 1, 0, 0, 32'h08, 32'h08, c_I | 32'h4, 1, 1, 0);
        step(0, 1, 0, 0, 32'h08, 32'h08, c_I | 32'h4, 1, 2, 0);
        step(0, 1, 0, 0, 32'h08, 32'h08, c_I | 32'h4, 1, 3, 0);
        step(0, 0, 0, 0, 32'h0C, 32'h0C, c_I | 32'h8, 1, 3, 0);

        // Advance to pc=0x20
        step(0, 0, 0, 0, 32'h10, 32'h10, c_I | 32'h0C, 1, 3, 0);
        step(0, 0, 0, 0, 32'h14, 32'h14, c_I | 32'h10, 1, 3, 0);
        step(0, 0, 0, 0, 32'h18, 32'h18, c_I | 32'h14, 1, 3, 0);
        step(0, 0, 0, 0, 32'h1C, 32'h1C, c_I | 32'h18, 1, 3, 0);
        step(0, 0, 0, 0, 32'h20, 32'h20, c_I | 32'h1C, 1, 3, 0);

        // Branch to 0x103 -> aligned 0x100, one bubble
        step(0, 0, 1, 32'h103, 32'h100, 32'h0, 32'h0, 0, 3, 1);
        step(0, 0, 0, 0, 32'h104, 32'h104, c_I | 32'h100, 1, 3, 1);

        // Branch and freeze together: branch wins, no stall count
        step(0, 1, 1, 32'h40, 32'h40, 32'h0, 32'h0, 0, 3, 2);
        step(0, 0, 0, 0, 32'h44, 32'h44, c_I | 32'h40, 1, 3, 2);

        // Back-to-back branches, then a one-cycle freeze
        step(0, 0, 1, 32'h200, 32'h200, 32'h0, 32'h0, 0, 3, 3);
        step(0, 0, 1, 32'h301, 32'h300, 32'h0, 32'h0, 0, 3, 4);
        step(0, 0, 0, 0, 32'h304, 32'h304, c_I | 32'h300, 1, 3, 4);
        step(0, 1, 0, 0, 32'h304, 32'h304, c_I | 32'h300, 1, 4, 4);

        // PC wrap from 0xFFFFFFFC
        step(0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 4, 5);
        step(0, 0, 0, 0, 32'h0, 32'h0, 32'hFFFF_FFFC, 1, 4, 5);

        // Long freeze saturates the 4-bit stall counter at 15
        for (int k = 1; k <= 21; k++) begin
            step(0, 1, 0, 0, 32'h0, 32'h0, 32'hFFFF_FFFC, 1,
                 ((4 + k) > 15) ? 32'd15 : 32'(4 + k), 5);
        end

        // Reset mid-freeze with a branch pending clears everything
        step(1, 1, 1, 32'h80, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step(0, 0, 0, 0, 32'h04, 32'h04, c_I | 32'h0, 1, 0, 0);

        // Drain the scoreboard with a bounded wait
        for (int w = 0; w < 5 && q.size() > 0; w++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
